// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: shared default geometry for the simple dual-port RAM family.
package sdp_ram_pkg;
   localparam int ADDR_WIDTH_DEF = 10;
   localparam int DATA_WIDTH_DEF = 9;
   localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;
endpackage

// File: rtl/sdp_ram_core.sv
// sdp_ram_core: unreset memory array with write port and read-first registered read,
// kept free of resets so synthesis maps it onto block RAM.
module sdp_ram_core
   import sdp_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] wa_i,
   input  logic [DATA_WIDTH-1:0] wd_i,
   input  logic [ADDR_WIDTH-1:0] ra_i,
   output logic [DATA_WIDTH-1:0] rd_o
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;
   always_ff @(posedge clk) begin
      if (we_i) mem_q[wa_i] <= wd_i;
      rd_q <= mem_q[ra_i];
   end
   assign rd_o = rd_q;
endmodule

// File: rtl/sdp_ram_1024x9.sv
// sdp_ram_1024x9: 1024x9 simple dual-port RAM, read latency 1 or 2 (OUTPUT_REG),
// read data held at 0 during and until the first edge after reset.
module sdp_ram_1024x9
   import sdp_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter bit OUTPUT_REG = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);
   logic [DATA_WIDTH-1:0] core_rd;
   logic [DATA_WIDTH-1:0] rd_d;
   logic                  vld_q;
   sdp_ram_core #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_core (
      .clk  (clk),
      .we_i (wr_en & rst_n),
      .wa_i (wr_addr),
      .wd_i (wr_data),
      .ra_i (rd_addr),
      .rd_o (core_rd)
   );
   // The read register lives in the unreset RAM; this flag gives it the async-clear behaviour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= 1'b0;
      else        vld_q <= 1'b1;
   end
   assign rd_d = vld_q ? core_rd : '0;
   generate
      if (OUTPUT_REG) begin : g_oreg
         logic [DATA_WIDTH-1:0] out_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) out_q <= '0;
            else        out_q <= rd_d;
         end
         assign rd_data = out_q;
      end else begin : g_noreg
         assign rd_data = rd_d;
      end
   endgenerate
endmodule

// File: tb/tb_sdp_ram_1024x9.sv
// tb_sdp_ram_1024x9: random and directed stimulus on latency-1 and latency-2 instances,
// checked against an array reference model.
module tb_sdp_ram_1024x9;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [9:0] wr_addr = '0;
   logic [9:0] rd_addr = '0;
   logic [8:0] wr_data = '0;
   logic [8:0] rd0, rd1;
   logic [8:0] ref_mem [1024];
   bit         known [1024];
   logic [8:0] e1 = '0, e2 = '0;
   bit         k1 = 1'b1, k2 = 1'b1;
   int         n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   sdp_ram_1024x9 #(.OUTPUT_REG(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd0)
   );
   sdp_ram_1024x9 #(.OUTPUT_REG(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd1)
   );

   task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: the model reads the old word before applying the write (read-first).
   task automatic cycle();
      @(posedge clk);
      if (!rst_n) begin
         e1 = '0; k1 = 1'b1; e2 = '0; k2 = 1'b1;
      end else begin
         e2 = e1; k2 = k1;
         e1 = ref_mem[rd_addr]; k1 = known[rd_addr];
         if (wr_en) begin
            ref_mem[wr_addr] = wr_data;
            known[wr_addr] = 1'b1;
         end
      end
      @(negedge clk);
      if (k1) chk("lat1", rd0, e1);
      if (k2) chk("lat2", rd1, e2);
   endtask

   initial begin
      for (int i = 0; i < 20; i++) begin
         rd_addr = 10'($urandom); wr_en = 1'($urandom);
         wr_addr = 10'($urandom); wr_data = 9'($urandom);
         cycle();
         chk("rst_hold0", rd0, 9'h000);
         chk("rst_hold1", rd1, 9'h000);
      end
      rst_n = 1'b1; wr_en = 1'b0;
      #1 chk("rel_pre", rd0, 9'h000);
      for (int k = 1; k <= 1024; k++) begin
         wr_en = 1'b1; wr_addr = 10'(k); wr_data = 9'(512 - k);
         rd_addr = 10'($urandom);
         cycle();
      end
      wr_en = 1'b0;
      for (int k = 1; k <= 1024; k++) begin
         rd_addr = 10'(k);
         cycle();
         chk("fill_rd0", rd0, 9'(512 - k));
         if (k > 1) chk("fill_rd1", rd1, 9'(513 - k));
      end
      wr_en = 1'b1; wr_addr = 10'd5; wr_data = 9'h0AA; rd_addr = 10'($urandom);
      cycle();
      wr_data = 9'h155; rd_addr = 10'd5;
      cycle();
      chk("coll_old", rd0, 9'h0AA);
      wr_en = 1'b0;
      cycle();
      chk("coll_new", rd0, 9'h155);
      wr_addr = 10'd7; wr_data = 9'h123; rd_addr = 10'd100;
      cycle();
      rd_addr = 10'd7;
      cycle();
      chk("wen_gate", rd0, 9'h1F9);
      for (int i = 0; i < 3000; i++) begin
         wr_en = 1'($urandom);
         wr_addr = (i < 1500) ? 10'($urandom_range(0, 15)) : 10'($urandom);
         rd_addr = (i < 1500) ? 10'($urandom_range(0, 15)) : 10'($urandom);
         wr_data = 9'($urandom);
         cycle();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rd_addr = 10'(i + 300);
         cycle();
      end
      rst_n = 1'b0;
      #1;
      chk("async0", rd0, 9'h000);
      chk("async1", rd1, 9'h000);
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_addr = 10'($urandom); wr_data = 9'($urandom);
         rd_addr = 10'($urandom);
         cycle();
         chk("mid_rst0", rd0, 9'h000);
      end
      rst_n = 1'b1; wr_en = 1'b0;
      #1 chk("mid_rel", rd1, 9'h000);
      for (int k = 0; k < 1024; k++) begin
         rd_addr = 10'(k);
         cycle();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
